// File: rtl/tt_um_seq_divider_hhrb98.sv
// ============================================================================
// Module   : tt_um_seq_divider_hhrb98
// Purpose  : Sequential 8-bit / 4-bit unsigned restoring divider, one quotient
//            bit per clock, with busy/done/dz status. Optional macro
//            DIV_ZERO_TRAP_EN short-circuits division by zero.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tt_um_seq_divider_hhrb98 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [7:0] c_UIO_OE   = 8'b1110_0000;
    localparam logic [2:0] c_LAST_CNT = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_nshift, w_nshift_nxt;
    logic [3:0] r_div, w_div_nxt;
    logic [3:0] r_p, w_p_nxt;
    logic [7:0] r_q, w_q_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_qout, w_qout_nxt;
    logic [3:0] r_rout, w_rout_nxt;
    logic       r_dz, w_dz_nxt;

    logic [3:0] w_div_in;
    logic       w_start;
    logic       w_rsel;
    logic       w_trap;
    logic [4:0] w_t;
    logic [4:0] w_diff;
    logic       w_qbit;
    logic [3:0] w_p_step;
    logic [7:0] w_q_step;
    logic       w_unused_bits;

    assign w_div_in      = uio_in[3:0];
    assign w_start       = uio_in[4];
    assign w_rsel        = uio_in[5];
    assign w_unused_bits = &{1'b0, uio_in[7:6]};

`ifdef DIV_ZERO_TRAP_EN
    assign w_trap = (w_div_in == 4'd0);
`else
    assign w_trap = 1'b0;
`endif

    // One restoring step: remainder stays below D, so 5 bits suffice for T.
    assign w_t      = {r_p, r_nshift[7]};
    assign w_diff   = w_t - {1'b0, r_div};
    assign w_qbit   = (w_t >= {1'b0, r_div});
    assign w_p_step = w_qbit ? w_diff[3:0] : w_t[3:0];
    assign w_q_step = {r_q[6:0], w_qbit};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_nshift <= 8'd0;
            r_div    <= 4'd0;
            r_p      <= 4'd0;
            r_q      <= 8'd0;
            r_cnt    <= 3'd0;
            r_qout   <= 8'd0;
            r_rout   <= 4'd0;
            r_dz     <= 1'b0;
        end else if (ena) begin
            r_state  <= w_state_nxt;
            r_nshift <= w_nshift_nxt;
            r_div    <= w_div_nxt;
            r_p      <= w_p_nxt;
            r_q      <= w_q_nxt;
            r_cnt    <= w_cnt_nxt;
            r_qout   <= w_qout_nxt;
            r_rout   <= w_rout_nxt;
            r_dz     <= w_dz_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_nshift_nxt = r_nshift;
        w_div_nxt    = r_div;
        w_p_nxt      = r_p;
        w_q_nxt      = r_q;
        w_cnt_nxt    = r_cnt;
        w_qout_nxt   = r_qout;
        w_rout_nxt   = r_rout;
        w_dz_nxt     = r_dz;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_dz_nxt = w_trap;
                    if (w_trap) begin
                        w_state_nxt = S_DONE;
                        w_qout_nxt  = 8'hFF;
                        w_rout_nxt  = ui_in[3:0];
                    end else begin
                        w_state_nxt  = S_RUN;
                        w_nshift_nxt = ui_in;
                        w_div_nxt    = w_div_in;
                        w_p_nxt      = 4'd0;
                        w_q_nxt      = 8'd0;
                        w_cnt_nxt    = 3'd0;
                    end
                end
            end
            S_RUN: begin
                w_p_nxt      = w_p_step;
                w_q_nxt      = w_q_step;
                w_nshift_nxt = {r_nshift[6:0], 1'b0};
                w_cnt_nxt    = r_cnt + 3'd1;
                // Results are published only when the eighth step lands.
                if (r_cnt == c_LAST_CNT) begin
                    w_state_nxt = S_DONE;
                    w_qout_nxt  = w_q_step;
                    w_rout_nxt  = w_p_step;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign uo_out  = w_rsel ? {4'b0000, r_rout} : r_qout;
    assign uio_out = {(r_state == S_DONE), (r_state == S_RUN), r_dz, 5'b00000};
    assign uio_oe  = c_UIO_OE;

endmodule

`default_nettype wire

// File: tb/tb_tt_um_seq_divider_hhrb98.sv
// Scoreboard bench for tt_um_seq_divider_hhrb98: directed divisions push
// expected {Q,R,dz}; a monitor pops and checks on each rising done.
`default_nettype none

module tb_tt_um_seq_divider_hhrb98;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] n_in = 8'd0;
    logic [3:0] d_in = 4'd0;
    logic       start = 1'b0;
    logic       rsel = 1'b0;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

`ifdef DIV_ZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    assign ui_in  = n_in;
    assign uio_in = {2'b00, rsel, start, d_in};

    always #5 clk = ~clk;

    tt_um_seq_divider_hhrb98 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: owns rsel so it can read both quotient and remainder.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (uio_out[7] && !prev_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    rsel = 1'b0;
                    #1;
                    check("quotient", {24'd0, uo_out}, {24'd0, e.q});
                    rsel = 1'b1;
                    #1;
                    check("remainder", {24'd0, uo_out}, {28'd0, e.r});
                    rsel = 1'b0;
                    check("dz", {31'd0, uio_out[5]}, {31'd0, e.dz});
                    check("busy_at_done", {31'd0, uio_out[6]}, 32'd0);
                end
            end
            prev_done = uio_out[7];
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait for done, counting posedges; optional mid-run start glitch and ena gap.
    task automatic wait_done(input string name, input int elat, input int glitch_at, input int ena_at);
        int cnt;
        cnt = 0;
        while (!uio_out[7] && cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (cnt == glitch_at) begin
                n_in = 8'd9; d_in = 4'd2; start = 1'b1;
            end
            if (cnt == glitch_at + 1) start = 1'b0;
            if (cnt == ena_at) ena = 1'b0;
            if (cnt == ena_at + 1) check("busy_while_gated", {31'd0, uio_out[6]}, 32'd1);
            if (cnt == ena_at + 3) ena = 1'b1;
        end
        check(name, cnt, elat);
    endtask

    task automatic run_div(input [7:0] n, input [3:0] d, input [7:0] eq, input [3:0] er,
                           input logic edz, input int elat, input int glitch_at, input int ena_at);
        exp_t e;
        @(negedge clk);
        n_in = n; d_in = d; start = 1'b1;
        e.q = eq; e.r = er; e.dz = edz;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (elat == 0) begin
            check("trap_done", {31'd0, uio_out[7]}, 32'd1);
            check("trap_busy", {31'd0, uio_out[6]}, 32'd0);
        end else begin
            check("busy_after_start", {31'd0, uio_out[6]}, 32'd1);
            check("done_cleared", {31'd0, uio_out[7]}, 32'd0);
            wait_done("latency", elat, glitch_at, ena_at);
        end
    endtask

    initial begin
        exp_t e;
        int   cnt;
        #200000;
        $display("FAIL watchdog: timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_uo_out", {24'd0, uo_out}, 32'd0);
        check("reset_uio_out", {24'd0, uio_out}, 32'd0);
        check("uio_oe", {24'd0, uio_oe}, 32'hE0);
        rst_n = 1'b1;

        // Divide by zero from IDLE so done shows a clean rising edge.
        run_div(8'hA7, 4'd0, 8'hFF, 4'h7, TRAP, TRAP ? 0 : 8, 100, 100);

        run_div(8'd200, 4'd7, 8'h1C, 4'd4, 1'b0, 8, 100, 100);
        run_div(8'd255, 4'd1, 8'hFF, 4'd0, 1'b0, 8, 100, 100);
        run_div(8'd5,   4'd15, 8'h00, 4'd5, 1'b0, 8, 100, 100);
        run_div(8'd0,   4'd9, 8'h00, 4'd0, 1'b0, 8, 100, 100);

        // Start/operand change at k+3 must be ignored.
        run_div(8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 8, 2, 100);

        // Enable gap of 3 cycles during RUN.
        run_div(8'd200, 4'd7, 8'h1C, 4'd4, 1'b0, 11, 100, 2);
        check("uio_oe_after_gate", {24'd0, uio_oe}, 32'hE0);

        // Start held through DONE restarts at k+9 with current inputs.
        @(negedge clk);
        n_in = 8'd100; d_in = 4'd3; start = 1'b1;
        e.q = 8'd33; e.r = 4'd1; e.dz = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        wait_done("held_latency1", 8, 100, 100);
        n_in = 8'd50; d_in = 4'd6;
        e.q = 8'd8; e.r = 4'd2; e.dz = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("held_restart_busy", {31'd0, uio_out[6]}, 32'd1);
        wait_done("held_latency2", 8, 100, 100);

        // Reset at edge k+4 of a run aborts it.
        @(negedge clk);
        n_in = 8'd100; d_in = 4'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_uo_out", {24'd0, uo_out}, 32'd0);
        check("midreset_uio_out", {24'd0, uio_out}, 32'd0);
        rst_n = 1'b1;
        run_div(8'd50, 4'd6, 8'd8, 4'd2, 1'b0, 8, 100, 100);

        // Trap dz clears on the next accepted start.
        do_reset();
        run_div(8'hA7, 4'd0, 8'hFF, 4'h7, TRAP, TRAP ? 0 : 8, 100, 100);
        run_div(8'd9, 4'd2, 8'd4, 4'd1, 1'b0, 8, 100, 100);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tt_um_seq_divider_hhrb98.md
# tt_um_seq_divider_hhrb98

Sequential 8-bit ÷ 4-bit unsigned restoring divider in the Tiny Tapeout user-project wrapper. It is the inverse-operation companion to the team's 4×4 array multiplier tile: a product-width dividend and a nibble divisor are accepted on a start pulse. The block produces an 8-bit quotient and a 4-bit remainder one bit per clock under a small FSM with busy/done status.

## Interface
- No parameters; widths are fixed by the wrapper pinout.
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  design enable; when 0, all registers hold.
- ui_in  in  8  dividend N[7:0].
- uio_in  in  8  [3:0] divisor D, [4] start, [5] rsel (output select), [7:6] unused.
- uo_out  out  8  rsel=0: quotient Q[7:0]; rsel=1: {4'b0000, R[3:0]}. Combinational mux of registered results.
- uio_out  out  8  [7] done, [6] busy, [5] dz (divide-by-zero flag), [4:0] driven 0.
- uio_oe  out  8  constant 8'b1110_0000.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - latch N into shift register and D into divisor register;
  - clear partial remainder P[3:0] and bit counter cnt[2:0];
  - clear done and dz; go to RUN.
- Start is level-sampled, not edge-detected. Start held high in DONE restarts immediately. Start in RUN is ignored.
- RUN, one step per cycle, MSB first:
  - T[4:0] = {P, Nshift[7]};
  - if T ≥ {1'b0,D}: P ← (T − D)[3:0], qbit = 1; else P ← T[3:0], qbit = 0;
  - quotient shift register ← {q[6:0], qbit}; Nshift ← Nshift << 1; cnt++.
- Width rule: T ≤ 2·D−1 ≤ 29 fits 5 bits. The remainder after each step is < D, so it fits in 4 bits.
- After the 8th step (cnt wraps 7→0):
  - Q/R output registers ← final quotient/remainder;
  - done ← 1, busy ← 0; go to DONE.
- Q/R output registers change only on completion. During RUN they hold the previous result.
- D = 0 with no trap: the algorithm runs normally, giving Q = 0xFF and R = N[3:0], with dz = 0.
- ena = 0: FSM, counter, datapath and outputs hold; start is not sampled.
- Reset (rst_n = 0 at a posedge, any state, including mid-RUN):
  - state IDLE; Q, R, cnt, P and the shift registers all 0;
  - done = 0, busy = 0, dz = 0.

## Timing
- Start sampled at posedge k: busy = 1 after edge k.
- Steps occur at edges k+1 … k+8.
- done = 1 and Q/R valid after edge k+8. Latency is 8 cycles from the start edge.
- Back-to-back operation: start held at edge k+9 begins the next division. Throughput is one result per 9 cycles.
- Operand inputs are only sampled at the start edge. Changing them during RUN has no effect.
- uo_out follows rsel combinationally, with zero-cycle select latency.

## Configuration
- DIV_ZERO_TRAP_EN defined:
  - start with D = 0 skips RUN: at edge k go directly to DONE;
  - Q ← 0xFF, R ← N[3:0], dz ← 1, done = 1 after edge k, busy never asserts.
- Undefined:
  - D = 0 runs the full 8-cycle RUN and yields the same Q/R;
  - dz is tied to 0.
- dz clears on the next accepted start or on reset.

## Test plan
- Basic divide: N = 200, D = 7, start one cycle → busy for 8 cycles. After edge k+8: done = 1, Q = 0x1C (rsel=0), uo_out = 0x04 (rsel=1).
- Extremes: N = 255, D = 1 → Q = 0xFF, R = 0. N = 5, D = 15 → Q = 0x00, R = 5. N = 0, D = 9 → Q = 0, R = 0.
- Divide-by-zero: N = 0xA7, D = 0 → Q = 0xFF, R = 0x7.
  - With DIV_ZERO_TRAP_EN: done and dz are 1 after the start edge, busy stays 0.
  - Without it: done at k+8, dz = 0.
- Start/operand protection: N = 100, D = 3; pulse start again at k+3 with N = 9, D = 2 → ignored, result Q = 33, R = 1 at k+8. Start held high through DONE → a new run begins at k+9 with the current inputs.
- Reset mid-operation: rst_n = 0 at edge k+4 → state IDLE, uo_out = 0, uio_out = 0. A subsequent start with N = 50, D = 6 yields Q = 8, R = 2.
- Enable gating: deassert ena for 3 cycles during RUN → completion delayed by exactly 3 cycles, same result. uio_oe reads 0xE0 at all times.
